// File: rtl/cache_fill_fsm_if.sv
// Cache-fill engine bus: cache-side miss/array-write signals
// plus the memory-side read request and return channel.
//
// Signals (master = fill engine, slave = cache/memory side):
//   miss_detected     : lookup missed this cycle
//   miss_address      : byte address of the missing access
//   fsm_busy          : stall request to the pipeline
//   write_data_array  : data-array write enable
//   write_tag_array   : tag-array write enable (line valid)
//   fill_word_idx     : word index within block for the write
//   fill_data         : word written into the data array
//   memory_address    : byte address of the memory read
//   mem_read_en       : memory read request strobe
//   memory_data_valid : memory returns one word this cycle
//   memory_data       : returned word
interface cache_fill_fsm_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              fsm_busy;
    logic              write_data_array;
    logic              write_tag_array;
    logic [2:0]        fill_word_idx;
    logic [DATA_W-1:0] fill_data;
    logic [ADDR_W-1:0] memory_address;
    logic              mem_read_en;
    logic              memory_data_valid;
    logic [DATA_W-1:0] memory_data;

    modport master (
        input  miss_detected,
        input  miss_address,
        input  memory_data_valid,
        input  memory_data,
        output fsm_busy,
        output write_data_array,
        output write_tag_array,
        output fill_word_idx,
        output fill_data,
        output memory_address,
        output mem_read_en
    );

    modport slave (
        output miss_detected,
        output miss_address,
        output memory_data_valid,
        output memory_data,
        input  fsm_busy,
        input  write_data_array,
        input  write_tag_array,
        input  fill_word_idx,
        input  fill_data,
        input  memory_address,
        input  mem_read_en
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: stalls the pipeline on a miss, issues
// one pipelined memory read per word of the block, writes each
// returned word into the data array and the tag with the last.
//
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : cache_fill_fsm_if.master (miss input, array writes,
//           memory request/return channel)
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cache_fill_fsm_if.master bus
);
    localparam int IDX_W  = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_W  = $clog2(WORDS_PER_BLOCK * DATA_W / 8);
    localparam int BYTE_W = OFF_W - IDX_W;
    localparam int CNT_W  = IDX_W + 1;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WORDS_PER_BLOCK);

    // Clears the in-block offset bits of a byte address.
    localparam logic [ADDR_W-1:0] BLK_MASK =
        ~ADDR_W'((1 << OFF_W) - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issueCnt;
    logic [CNT_W-1:0]  recvCnt;

    logic              busy;
    logic              wrData;
    logic              wrTag;
    logic [2:0]        fillIdx;
    logic [DATA_W-1:0] fillData;
    logic [ADDR_W-1:0] memAddr;
    logic              rdEn;
    logic [ADDR_W-1:0] wordOff;

    // Byte offset of the word being requested; base is block
    // aligned, so OR-ing it in can never carry into tag bits.
    assign wordOff = ADDR_W'({issueCnt[IDX_W-1:0], {BYTE_W{1'b0}}});

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        wrData    = 1'b0;
        wrTag     = 1'b0;
        fillIdx   = '0;
        fillData  = '0;
        memAddr   = '0;
        rdEn      = 1'b0;

        unique case (state)
            IDLE: begin
                // Stall in the miss cycle itself.
                busy = bus.miss_detected;
                if (bus.miss_detected) begin
                    stateNext = FILL;
                end
            end
            FILL: begin
                busy = 1'b1;
                if (issueCnt < FULL) begin
                    rdEn    = 1'b1;
                    memAddr = base | wordOff;
                end
                if (bus.memory_data_valid) begin
                    wrData   = 1'b1;
                    fillIdx  = 3'(recvCnt[IDX_W-1:0]);
                    fillData = bus.memory_data;
                    if (recvCnt == LAST) begin
                        wrTag     = 1'b1;
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Reset is synchronous, so the state register may still
        // hold FILL during the reset cycle; force outputs quiet.
        if (!rst_n) begin
            stateNext = IDLE;
            busy      = 1'b0;
            wrData    = 1'b0;
            wrTag     = 1'b0;
            fillIdx   = '0;
            fillData  = '0;
            memAddr   = '0;
            rdEn      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            base     <= '0;
            issueCnt <= '0;
            recvCnt  <= '0;
        end else begin
            state <= stateNext;
            unique case (state)
                IDLE: begin
                    if (bus.miss_detected) begin
                        base     <= bus.miss_address & BLK_MASK;
                        issueCnt <= '0;
                        recvCnt  <= '0;
                    end
                end
                FILL: begin
                    // Saturates at FULL: issue side stops there.
                    if (issueCnt < FULL) begin
                        issueCnt <= issueCnt + 1'b1;
                    end
                    if (bus.memory_data_valid) begin
                        if (recvCnt == LAST) begin
                            recvCnt <= '0;
                        end else begin
                            recvCnt <= recvCnt + 1'b1;
                        end
                    end
                end
                default: begin
                    issueCnt <= '0;
                    recvCnt  <= '0;
                end
            endcase
        end
    end

    assign bus.fsm_busy         = busy;
    assign bus.write_data_array = wrData;
    assign bus.write_tag_array  = wrTag;
    assign bus.fill_word_idx    = fillIdx;
    assign bus.fill_data        = fillData;
    assign bus.memory_address   = memAddr;
    assign bus.mem_read_en      = rdEn;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a small memory model
// (fixed 4-cycle latency or variable gaps between returns).
module tb_cache_fill_fsm;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cache_fill_fsm_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cache_fill_fsm #(
        .WORDS_PER_BLOCK(8),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
    );

    logic [15:0] reqQ[$];
    int          reqC[$];
    int          cyc     = 0;
    int          memMode = 0;
    int          nextRet = 0;
    int          gapIdx  = 0;
    int          gaps[8] = '{1, 3, 10, 2, 7, 1, 5, 4};
    int          tests   = 0;
    int          fails   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents at most one return per cycle, in request order.
    task automatic drive_mem();
        bit go;
        go = 1'b0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = '0;
        if (reqQ.size() > 0) begin
            if (memMode == 0)
                go = (cyc >= reqC[0] + 4);
            else
                go = (cyc >= reqC[0] + 1) && (cyc >= nextRet);
        end
        if (go) begin
            bus.memory_data_valid = 1'b1;
            bus.memory_data       = reqQ[0] ^ 16'hA5A5;
            void'(reqQ.pop_front());
            void'(reqC.pop_front());
            nextRet = cyc + gaps[gapIdx % 8];
            gapIdx++;
        end
    endtask

    task automatic end_cycle();
        if (bus.mem_read_en === 1'b1) begin
            reqQ.push_back(bus.memory_address);
            reqC.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_busy"}, bus.fsm_busy, 0);
        chk({tag, "_wrd"}, bus.write_data_array, 0);
        chk({tag, "_wrt"}, bus.write_tag_array, 0);
        chk({tag, "_rden"}, bus.mem_read_en, 0);
    endtask

    task automatic run_fill(input logic [15:0] ma, input int mode,
                            input bit hold, input bit pulse);
        logic [15:0] base;
        int  k, nRecv, nRd, busyCnt;
        bit  done, v;
        base    = ma & 16'hFFF0;
        k       = 0;
        nRecv   = 0;
        nRd     = 0;
        busyCnt = 0;
        done    = 1'b0;
        memMode = mode;
        nextRet = 0;
        gapIdx  = 0;
        while (!done && k < 200) begin
            bus.miss_detected = (k == 0) || hold || (pulse && k == 3);
            bus.miss_address  = (pulse && k == 3) ? 16'h4000 : ma;
            drive_mem();
            v = bus.memory_data_valid;
            #1;
            chk("busy", bus.fsm_busy, 1);
            busyCnt++;
            chk("rd_en", bus.mem_read_en, (k >= 1 && k <= 8));
            if (bus.mem_read_en === 1'b1) nRd++;
            if (k >= 1 && k <= 8)
                chk("addr", bus.memory_address, base + 2 * (k - 1));
            chk("wr_data", bus.write_data_array, v);
            if (v) begin
                chk("idx", bus.fill_word_idx, nRecv);
                chk("data", bus.fill_data, (base + 2 * nRecv) ^ 16'hA5A5);
                chk("tag", bus.write_tag_array, nRecv == 7);
                nRecv++;
                if (nRecv == 8) done = 1'b1;
            end else begin
                chk("tag_novalid", bus.write_tag_array, 0);
            end
            end_cycle();
            k++;
        end
        chk("fill_done", done, 1);
        if (mode == 0) chk("busy_cycles", busyCnt, 13);
        bus.miss_detected = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_mem();
            #1;
            idle_checks("post");
            if (bus.mem_read_en === 1'b1) nRd++;
            end_cycle();
        end
        chk("reads", nRd, 8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.miss_detected     = 1'b1;
        bus.miss_address      = 16'h1234;
        bus.memory_data_valid = 1'b1;
        bus.memory_data       = 16'hBEEF;
        rst_n                 = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            #1;
            idle_checks("reset");
            chk("reset_idx", bus.fill_word_idx, 0);
            chk("reset_fdata", bus.fill_data, 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        bus.miss_detected = 1'b0;
        drive_mem();
        #1;
        idle_checks("idle");
        end_cycle();

        // Stray return while idle.
        drive_mem();
        bus.memory_data_valid = 1'b1;
        bus.memory_data       = 16'hDEAD;
        #1;
        idle_checks("stray");
        chk("stray_fdata", bus.fill_data, 0);
        end_cycle();
        drive_mem();
        #1;
        idle_checks("stray_after");
        end_cycle();

        run_fill(16'h1237, 0, 1'b0, 1'b0);
        run_fill(16'hFFF2, 0, 1'b1, 1'b0);
        run_fill(16'h2000, 0, 1'b0, 1'b1);

        // Reset after the third returned word.
        memMode = 0;
        for (int k = 0; k < 8; k++) begin
            bus.miss_detected = (k == 0);
            bus.miss_address  = 16'h1000;
            drive_mem();
            #1;
            chk("pre_rst_busy", bus.fsm_busy, 1);
            end_cycle();
        end
        rst_n = 1'b0;
        bus.miss_detected = 1'b0;
        drive_mem();
        #1;
        idle_checks("in_rst");
        chk("in_rst_idx", bus.fill_word_idx, 0);
        chk("in_rst_fdata", bus.fill_data, 0);
        chk("in_rst_addr", bus.memory_address, 0);
        end_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_mem();
            #1;
            idle_checks("late_ret");
            end_cycle();
        end

        run_fill(16'h0040, 0, 1'b0, 1'b0);
        run_fill(16'h3000, 1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling engine between the L1 cache (I- or D-side) and the multi-cycle main memory in the phase-3 pipeline.
- On a cache miss it stalls the pipeline and issues one pipelined read per word of the missing 16-byte block.
- It writes each returned word into the cache data array, writes the tag array with the last word, then releases the stall.
- One instance per cache. When both caches miss together, the I/D memory arbiter serialises them upstream.

Parameters:
WORDS_PER_BLOCK, 8, 16-bit words per cache block (block = 16 bytes)
ADDR_W, 16, byte-address width
DATA_W, 16, memory/cache word width

Ports:
clk  in  1  clock
rst_n  in  1  reset
miss_detected  in  1  cache lookup missed this cycle (from tag compare)
miss_address  in  ADDR_W  byte address of the missing access
fsm_busy  out  1  stall request to pipeline / hold cache request
write_data_array  out  1  cache data-array write enable
write_tag_array  out  1  cache tag-array write enable (marks line valid)
fill_word_idx  out  3  word index within block for data-array write
fill_data  out  DATA_W  word to write into data array
memory_address  out  ADDR_W  byte address of read request to memory
mem_read_en  out  1  read request strobe to memory
memory_data_valid  in  1  memory returning one word this cycle (in request order)
memory_data  in  DATA_W  returned word

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- States: IDLE, FILL.
- Reset state is IDLE. Registers reset: base=0, issue_cnt=0, recv_cnt=0.
- All outputs read 0 under reset.
- IDLE:
  - fsm_busy = miss_detected (combinational, so the stall asserts in the miss cycle).
  - On miss_detected at edge T: base <= miss_address & ~(ADDR_W)'hF, issue_cnt <= 0, recv_cnt <= 0, state <= FILL.
- FILL, issue side:
  - While issue_cnt < 8: mem_read_en=1, memory_address = base + 2*issue_cnt; issue_cnt increments every cycle.
  - No back-pressure: memory accepts one request per cycle.
  - Requests therefore occupy cycles T+1..T+8; mem_read_en=0 afterwards.
- FILL, return side:
  - Each cycle memory_data_valid=1: write_data_array=1, fill_word_idx=recv_cnt, fill_data=memory_data (combinational pass-through); recv_cnt increments.
  - Returns may overlap issues.
- Completion:
  - When memory_data_valid=1 and recv_cnt==7, write_tag_array=1 in the same cycle as the last data write, and state <= IDLE.
  - fsm_busy drops the following cycle. The replayed access then hits.
- fsm_busy = 1 throughout FILL.
- Timing with the 4-cycle memory: valids arrive T+5..T+12, fsm_busy is high T..T+12 (13 cycles), and write_tag_array pulses at T+12.
- Outputs in IDLE: write_data_array, write_tag_array and mem_read_en are 0. fill_word_idx and fill_data are don't-care but driven 0.
- Boundaries:
  - miss_detected during FILL: ignored, base unchanged.
  - memory_data_valid in IDLE: ignored, no array write.
  - Unaligned miss_address (e.g. 0x1237): base 0x1230.
  - Top block base 0xFFF0: last request 0xFFFE, no wrap, no overflow into addr bits.
  - Counters are 4 bits. issue_cnt saturates at 8; recv_cnt never exceeds 7 in FILL.
  - Reset mid-FILL: next cycle IDLE, counters 0, all outputs 0. Late memory returns arriving after reset are ignored.
  - A miss asserted on the same edge the FILL completes is not accepted on that edge (state was FILL). It is accepted on a later cycle because the cache still misses.
- Latency invariant: exactly 8 data-array writes and 1 tag write per accepted miss, with no dependence on memory latency.

Test Plan:
- Miss at 0x1237, 4-cycle memory returning addr^0xA5A5 -> 8 requests 0x1230..0x123E on consecutive cycles. Data writes idx0..7 carry 0xB795..0xB79B. Tag write coincides with idx7. fsm_busy high exactly 13 cycles.
- Miss at 0xFFF2 -> requests 0xFFF0..0xFFFE, no 0x0000 request, 8 writes then IDLE.
- Second miss_detected pulse (0x4000) mid-FILL of 0x2000 -> all requests stay in 0x2000..0x200E, and no second fill starts until fsm_busy falls.
- Stray memory_data_valid=1 with 0xDEAD while IDLE -> write_data_array=0, write_tag_array=0, fsm_busy=0.
- rst_n=0 for one cycle after 3rd returned word -> next cycle IDLE, all outputs 0. Remaining 5 returns produce no writes. A new miss at 0x0040 then completes a normal 8-word fill.
- Memory with variable 1–10-cycle gaps between valids -> fill_word_idx strictly 0..7 in order, tag write only on the 8th valid.
